// File: rtl/sdr_wrdata_reader.sv
// Burst reader for the SDRAM write-data path: pops a requested number of words
// from a first-word-fall-through FIFO and presents them through a registered output stage.
module sdr_wrdata_reader #(
  parameter int W  = 32,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic [LW-1:0] req_len,
  output logic          req_ready,
  input  logic          fifo_empty,
  input  logic [W-1:0]  fifo_rd_data,
  output logic          fifo_rd_en,
  output logic [W-1:0]  dout_data,
  output logic          dout_valid,
  input  logic          dout_next,
  output logic          burst_done,
  output logic          underrun,
  input  logic          underrun_clr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [W-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          und_q, und_d;
  logic          pop;

  // Pops are gated by rem != 0, so rem can never wrap below zero.
  always_comb begin
    pop = 1'b0;
    case (state_q)
      FILL:    pop = ~fifo_empty;
      STREAM:  pop = dout_next & (rem_q != '0) & ~fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    und_d   = und_q;

    if ((state_q == FILL) && dout_next) begin
      und_d = 1'b1;
    end else if (underrun_clr) begin
      und_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_len != '0) begin
            rem_d   = req_len;
            state_d = FILL;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FILL: begin
        if (pop) begin
          data_d  = fifo_rd_data;
          valid_d = 1'b1;
          rem_d   = rem_q - LW'(1);
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (dout_next) begin
          if (pop) begin
            data_d = fifo_rd_data;
            rem_d  = rem_q - LW'(1);
          end else if (rem_q != '0) begin
            valid_d = 1'b0;
            state_d = FILL;
          end else begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      und_q   <= und_d;
    end
  end

  assign fifo_rd_en = pop & ~reset;
  assign req_ready  = (state_q == IDLE);
  assign dout_data  = data_q;
  assign dout_valid = valid_q;
  assign burst_done = done_q;
  assign underrun   = und_q;

endmodule

// File: tb/tb_sdr_wrdata_reader.sv
// Self-checking bench for sdr_wrdata_reader: a queue-based FWFT FIFO model feeds the DUT,
// directed timing steps plus randomized bursts are checked against in-order delivery rules.
module tb_sdr_wrdata_reader;

  localparam int W  = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic [LW-1:0] req_len;
  logic          req_ready;
  logic          fifo_empty = 1'b1;
  logic [W-1:0]  fifo_rd_data;
  logic          fifo_rd_en;
  logic [W-1:0]  dout_data;
  logic          dout_valid;
  logic          dout_next;
  logic          burst_done;
  logic          underrun;
  logic          underrun_clr;

  // FIFO model storage and write port driven by the stimulus
  logic [W-1:0]  mem [0:255];
  logic [7:0]    wptr = 8'd0;
  logic [7:0]    rptr = 8'd0;
  logic          wrEn = 1'b0;
  logic [W-1:0]  wrData = '0;

  int            testsRun = 0;
  int            testsFailed = 0;
  int            popCount = 0;
  logic [W-1:0]  pendQ[$];
  logic [W-1:0]  gotQ[$];
  logic [W-1:0]  writeQ[$];

  sdr_wrdata_reader #(.W(W), .LW(LW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_len      (req_len),
    .req_ready    (req_ready),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .dout_data    (dout_data),
    .dout_valid   (dout_valid),
    .dout_next    (dout_next),
    .burst_done   (burst_done),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #5 clk = ~clk;

  // First-word-fall-through FIFO with a registered empty flag; it ignores the DUT reset.
  assign fifo_rd_data = mem[rptr];
  always @(posedge clk) begin
    if (wrEn) mem[wptr] <= wrData;
    wptr       <= wptr + (wrEn ? 8'd1 : 8'd0);
    rptr       <= rptr + (fifo_rd_en ? 8'd1 : 8'd0);
    fifo_empty <= ((wptr + (wrEn ? 8'd1 : 8'd0)) == (rptr + (fifo_rd_en ? 8'd1 : 8'd0)));
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples the settled cycle, tracks pops and consumed words, then advances one clock.
  task automatic cycle();
    #1;
    if (dout_valid && dout_next) begin
      check("pending_depth", 32'(pendQ.size()), 32'd1);
      gotQ.push_back(dout_data);
      if (pendQ.size() > 0) check("word_order", dout_data, pendQ.pop_front());
    end
    if (fifo_rd_en) begin
      popCount++;
      check("pop_not_empty", {31'd0, fifo_empty}, 32'd0);
      pendQ.push_back(fifo_rd_data);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expectNow(input string tag, input logic v, input logic [W-1:0] d,
                           input logic r, input logic done);
    #1;
    check({tag, "_valid"}, {31'd0, dout_valid}, {31'd0, v});
    if (v) check({tag, "_data"}, dout_data, d);
    check({tag, "_rden"}, {31'd0, fifo_rd_en}, {31'd0, r});
    check({tag, "_done"}, {31'd0, burst_done}, {31'd0, done});
  endtask

  task automatic pushWord(input logic [W-1:0] d);
    wrEn   = 1'b1;
    wrData = d;
    cycle();
    wrEn   = 1'b0;
  endtask

  task automatic request(input logic [LW-1:0] len);
    req_valid = 1'b1;
    req_len   = len;
    dout_next = 1'b0;
    wrEn      = 1'b0;
    #1;
    check("req_ready", {31'd0, req_ready}, 32'd1);
    cycle();
    req_valid = 1'b0;
  endtask

  task automatic runUntilIdle(input int budget, input bit randomMode);
    bit seen;
    logic [7:0] lvl;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (burst_done) begin
        seen = 1'b1;
        break;
      end
      dout_next = dout_valid && (!randomMode || ($urandom_range(0, 3) != 0));
      wrEn = 1'b0;
      lvl = wptr - rptr;
      if (randomMode && (lvl < 8'd200) && ($urandom_range(0, 1) == 1)) begin
        wrEn   = 1'b1;
        wrData = $urandom;
        writeQ.push_back(wrData);
      end
      cycle();
    end
    wrEn = 1'b0;
    dout_next = 1'b0;
    check("burst_done_seen", {31'd0, seen}, 32'd1);
    cycle();
    check("burst_done_pulse", {31'd0, burst_done}, 32'd0);
  endtask

  initial begin
    int p0;
    int g0;
    logic [7:0] left;
    logic [7:0] left2;
    logic [LW-1:0] len;

    reset = 1'b1;
    req_valid = 1'b0;
    req_len = '0;
    dout_next = 1'b0;
    underrun_clr = 1'b0;

    // Reset state, then dout_next in IDLE must not raise underrun
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_dout_data", dout_data, 32'd0);
    check("rst_burst_done", {31'd0, burst_done}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dout_next = 1'b1;
    for (int c = 0; c < 3; c++) cycle();
    check("idle_next_underrun", {31'd0, underrun}, 32'd0);
    check("idle_req_ready", {31'd0, req_ready}, 32'd1);

    // Back-to-back burst of four with dout_next held high
    dout_next = 1'b0;
    pushWord(32'h11);
    pushWord(32'h22);
    pushWord(32'h33);
    pushWord(32'h44);
    p0 = popCount;
    dout_next = 1'b1;
    for (int c = 0; c < 8; c++) begin
      req_valid = (c == 0);
      req_len   = 8'd4;
      expectNow($sformatf("b2b_c%0d", c), (c >= 2 && c <= 5), 32'h11 * (c - 1),
                (c >= 1 && c <= 4), (c == 6));
      cycle();
    end
    req_valid = 1'b0;
    check("b2b_pops", 32'(popCount - p0), 32'd4);
    check("b2b_fill_underrun", {31'd0, underrun}, 32'd1);
    dout_next = 1'b0;
    underrun_clr = 1'b1;
    cycle();
    underrun_clr = 1'b0;
    check("b2b_underrun_clr", {31'd0, underrun}, 32'd0);

    // Zero-length request with a word waiting in the FIFO
    pushWord(32'hA1);
    p0 = popCount;
    req_valid = 1'b1;
    req_len = 8'd0;
    expectNow("zero_c0", 1'b0, '0, 1'b0, 1'b0);
    cycle();
    req_valid = 1'b0;
    expectNow("zero_c1", 1'b0, '0, 1'b0, 1'b1);
    check("zero_req_ready", {31'd0, req_ready}, 32'd1);
    cycle();
    expectNow("zero_c2", 1'b0, '0, 1'b0, 1'b0);
    check("zero_pops", 32'(popCount - p0), 32'd0);
    check("zero_fifo_level", 32'(8'(wptr - rptr)), 32'd1);

    // Mid-burst stall: one word present, the rest arrive later
    gotQ.delete();
    for (int c = 0; c < 10; c++) begin
      req_valid = (c == 0);
      req_len   = 8'd3;
      dout_next = (c == 2 || c == 7 || c == 8);
      wrEn      = (c == 5 || c == 6);
      wrData    = (c == 5) ? 32'hA2 : 32'hA3;
      expectNow($sformatf("stall_c%0d", c), (c == 2 || c == 7 || c == 8),
                (c == 2) ? 32'hA1 : ((c == 7) ? 32'hA2 : 32'hA3),
                (c == 1 || c == 6 || c == 7), (c == 9));
      cycle();
    end
    wrEn = 1'b0;
    req_valid = 1'b0;
    dout_next = 1'b0;
    check("stall_count", 32'(gotQ.size()), 32'd3);
    if (gotQ.size() == 3) begin
      check("stall_w0", gotQ[0], 32'hA1);
      check("stall_w1", gotQ[1], 32'hA2);
      check("stall_w2", gotQ[2], 32'hA3);
    end
    check("stall_underrun", {31'd0, underrun}, 32'd0);

    // Underrun: set wins over clear, clear alone drops it, burst still completes
    gotQ.delete();
    request(8'd2);
    dout_next = 1'b1;
    check("und_before", {31'd0, underrun}, 32'd0);
    cycle();
    check("und_set", {31'd0, underrun}, 32'd1);
    underrun_clr = 1'b1;
    cycle();
    check("und_set_wins", {31'd0, underrun}, 32'd1);
    dout_next = 1'b0;
    cycle();
    underrun_clr = 1'b0;
    check("und_cleared", {31'd0, underrun}, 32'd0);
    pushWord(32'hC1);
    pushWord(32'hC2);
    runUntilIdle(50, 1'b0);
    check("und_count", 32'(gotQ.size()), 32'd2);
    if (gotQ.size() == 2) begin
      check("und_w0", gotQ[0], 32'hC1);
      check("und_w1", gotQ[1], 32'hC2);
    end
    check("und_after", {31'd0, underrun}, 32'd0);

    // Reset in the middle of an eight-word burst
    gotQ.delete();
    for (int i = 0; i < 8; i++) pushWord(32'hD000_0000 | 32'(i));
    request(8'd8);
    for (int i = 0; i < 50 && gotQ.size() < 3; i++) begin
      dout_next = dout_valid;
      cycle();
    end
    check("mid_consumed", 32'(gotQ.size()), 32'd3);
    dout_next = 1'b0;
    reset = 1'b1;
    pendQ.delete();
    #1;
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_valid", {31'd0, dout_valid}, 32'd0);
    check("mid_rst_data", dout_data, 32'd0);
    check("mid_rst_rden", {31'd0, fifo_rd_en}, 32'd0);
    check("mid_rst_underrun", {31'd0, underrun}, 32'd0);
    cycle();
    check("mid_rst_done", {31'd0, burst_done}, 32'd0);
    reset = 1'b0;
    left = wptr - rptr;
    check("mid_left", {31'd0, (left == 8'd4) || (left == 8'd5)}, 32'd1);
    for (int i = 0; i < 3 && i < gotQ.size(); i++)
      check($sformatf("mid_pre_w%0d", i), gotQ[i], 32'hD000_0000 | 32'(i));
    gotQ.delete();
    request(8'd4);
    runUntilIdle(60, 1'b0);
    check("mid_new_count", 32'(gotQ.size()), 32'd4);
    for (int i = 0; i < 4 && i < gotQ.size(); i++)
      check($sformatf("mid_new_w%0d", i), gotQ[i], 32'hD000_0000 | 32'(8 - int'(left) + i));
    left2 = wptr - rptr;
    if (left2 != 8'd0) begin
      request(left2);
      runUntilIdle(60, 1'b0);
    end

    // Randomized bursts: every burst pops and delivers exactly req_len words, in write order
    gotQ.delete();
    writeQ.delete();
    for (int b = 0; b < 30; b++) begin
      len = LW'($urandom_range(0, 6));
      p0 = popCount;
      g0 = gotQ.size();
      request(len);
      runUntilIdle(200, 1'b1);
      check($sformatf("rnd_pops_b%0d", b), 32'(popCount - p0), 32'(len));
      check($sformatf("rnd_words_b%0d", b), 32'(gotQ.size() - g0), 32'(len));
    end
    check("rnd_underrun", {31'd0, underrun}, 32'd0);
    for (int i = 0; i < gotQ.size() && i < writeQ.size(); i++)
      check($sformatf("rnd_w%0d", i), gotQ[i], writeQ[i]);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
